// File: rtl/reg_dump_reader_pkg.sv
// +----------------------------------------------------------------------+
// | reg_dump_reader_pkg : shared CPU constants (register index, FSM)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_dump_reader_pkg;

   localparam int unsigned c_reg_idx_w = 5;
   localparam int unsigned c_data_w    = 32;

   typedef logic [c_reg_idx_w-1:0] reg_idx_t;
   typedef logic [c_data_w-1:0]    reg_data_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_dump_reader_if.sv
// +----------------------------------------------------------------------+
// | reg_dump_reader_if : control, register-file read and word stream     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface reg_dump_reader_if;
   import reg_dump_reader_pkg::*;

   logic      start;
   logic      abort;
   reg_idx_t  rd_addr;
   reg_data_t rd_data;
   logic      out_valid;
   logic      out_ready;
   reg_idx_t  out_addr;
   reg_data_t out_data;
   logic      busy;
   logic      done;

   modport master (
      input  start, abort, rd_data, out_ready,
      output rd_addr, out_valid, out_addr, out_data, busy, done
   );

   modport slave (
      output start, abort, rd_data, out_ready,
      input  rd_addr, out_valid, out_addr, out_data, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/reg_dump_reader.sv
// +----------------------------------------------------------------------+
// | reg_dump_reader : walks registers FIRST_REG..LAST_REG out a          |
// | valid/ready stream, one word per two cycles.  Revision: 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_dump_reader
   import reg_dump_reader_pkg::*;
#(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   reg_dump_reader_if.master bus
);

   localparam reg_idx_t c_first = reg_idx_t'(FIRST_REG);
   localparam reg_idx_t c_last  = reg_idx_t'(LAST_REG);

   dump_state_t r_state;
   reg_idx_t    r_idx;
   logic        r_out_valid;
   reg_idx_t    r_out_addr;
   reg_data_t   r_out_data;
   logic        r_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_idx   <= c_first;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (bus.abort) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_out_data  <= bus.rd_data;
                  r_out_addr  <= r_idx;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               // abort outranks a handshake landing on the same edge
               if (bus.abort) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_idx == c_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Read address parks at 0 outside ISSUE so idle reads hit the zero register
   assign bus.rd_addr   = (r_state == ST_ISSUE) ? r_idx : '0;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_data  = r_out_data;
   assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// +----------------------------------------------------------------------+
// | tb_reg_dump_reader : directed self-checking bench for reg_dump_reader|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_dump_reader;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   reg_dump_reader_if bus();
   reg_dump_reader_if bus5();

   function automatic logic [31:0] rf_model(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : (32'h1000 + {27'd0, a});
   endfunction

   assign bus.rd_data  = rf_model(bus.rd_addr);
   assign bus5.rd_data = rf_model(bus5.rd_addr);

   reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) u_dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.out_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.out_addr); end
      n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", bus.rd_addr); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_dump();
      int k, words, dones, done_k, first_k;
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      tick();                      // edge N: start sampled
      bus.start = 1'b0;
      k = 0; words = 0; dones = 0; done_k = -1; first_k = -1;
      while (k < 200 && dones == 0) begin
         if (bus.out_valid) begin
            if (first_k < 0) first_k = k;
            n_checks++; if (bus.out_addr !== 5'(words)) begin n_fail++; $display("FAIL dump_addr: got %0d expected %0d", bus.out_addr, words); end
            n_checks++; if (bus.out_data !== rf_model(5'(words))) begin n_fail++; $display("FAIL dump_data: got %h expected %h", bus.out_data, rf_model(5'(words))); end
            words++;
         end else if (bus.busy && !bus.done) begin
            n_checks++; if (bus.rd_addr !== 5'(words)) begin n_fail++; $display("FAIL dump_rd_addr: got %0d expected %0d", bus.rd_addr, words); end
         end
         if (bus.done) begin dones++; done_k = k; end
         tick();
         k++;
      end
      n_checks++; if (dones != 1) begin n_fail++; $display("FAIL dump_done_seen: got %0d expected 1", dones); end
      n_checks++; if (words != 32) begin n_fail++; $display("FAIL dump_word_count: got %0d expected 32", words); end
      n_checks++; if (done_k != 64) begin n_fail++; $display("FAIL dump_done_latency: got %0d expected 64", done_k); end
      // valid already high in the cycle before edge N+2
      n_checks++; if (first_k != 1) begin n_fail++; $display("FAIL dump_first_valid: got %0d expected 1", first_k); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dump_done_width: got %b expected 0", bus.done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dump_idle_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL dump_idle_rd_addr: got %0d expected 0", bus.rd_addr); end
   endtask

   task automatic test_stall();
      int k;
      bit seen;
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      seen = 1'b0; k = 0;
      while (!seen && k < 100) begin
         if (bus.out_valid && bus.out_addr == 5'd7) seen = 1'b1;
         else begin tick(); k++; end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_reach7: got timeout expected word 7"); end
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", bus.out_valid); end
         n_checks++; if (bus.out_addr !== 5'd7) begin n_fail++; $display("FAIL stall_addr: got %0d expected 7", bus.out_addr); end
         n_checks++; if (bus.out_data !== 32'h1007) begin n_fail++; $display("FAIL stall_data: got %h expected 00001007", bus.out_data); end
      end
      bus.out_ready = 1'b1;
      seen = 1'b0; k = 0;
      while (!seen && k < 10) begin
         tick(); k++;
         if (bus.out_valid) seen = 1'b1;
      end
      n_checks++; if (bus.out_addr !== 5'd8) begin n_fail++; $display("FAIL stall_next_addr: got %0d expected 8", bus.out_addr); end
      n_checks++; if (bus.out_data !== 32'h1008) begin n_fail++; $display("FAIL stall_next_data: got %h expected 00001008", bus.out_data); end
      k = 0;
      while (!bus.done && k < 100) begin tick(); k++; end
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL stall_drain_done: got %b expected 1", bus.done); end
      tick();
   endtask

   task automatic test_abort();
      int k, seen_valid, seen_done;
      bit seen;
      // abort is ignored in IDLE, then kills the pass from ISSUE
      bus.out_ready = 1'b1;
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ignored: got busy %b expected 1", bus.busy); end
      tick();
      bus.abort = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_issue_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_issue_valid: got %b expected 0", bus.out_valid); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      seen = 1'b0; k = 0;
      while (!seen && k < 100) begin
         if (bus.out_valid && bus.out_addr == 5'd10) seen = 1'b1;
         else begin tick(); k++; end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_reach10: got timeout expected word 10"); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_send_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_send_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_send_done: got %b expected 0", bus.done); end
      seen_valid = 0; seen_done = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (bus.out_valid) seen_valid++;
         if (bus.done) seen_done++;
      end
      n_checks++; if (seen_valid != 0) begin n_fail++; $display("FAIL abort_no_words: got %0d expected 0", seen_valid); end
      n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", seen_done); end
   endtask

   task automatic test_reset_mid();
      int k, stray;
      bit seen;
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      seen = 1'b0; k = 0;
      while (!seen && k < 100) begin
         if (bus.out_valid && bus.out_addr == 5'd20) seen = 1'b1;
         else begin tick(); k++; end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach20: got timeout expected word 20"); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.out_addr !== 5'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0d expected 0", bus.out_addr); end
      n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", bus.out_data); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL rstmid_rd_addr: got %0d expected 0", bus.rd_addr); end
      stray = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_valid || bus.done || bus.busy) stray++;
      end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL rstmid_silent: got %0d active cycles expected 0", stray); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      seen = 1'b0; k = 0;
      while (!seen && k < 10) begin
         tick(); k++;
         if (bus.out_valid) seen = 1'b1;
      end
      n_checks++; if (bus.out_addr !== 5'd0) begin n_fail++; $display("FAIL rstmid_restart_addr: got %0d expected 0", bus.out_addr); end
      n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_restart_data: got %h expected 0", bus.out_data); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_cleanup_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_single_reg();
      int words, dones, done_k;
      bus5.out_ready = 1'b1;
      bus5.start = 1'b1;
      tick();
      // start stays high through two busy edges and must be ignored there
      words = 0; dones = 0; done_k = -1;
      for (int k = 0; k < 20; k++) begin
         if (bus5.out_valid) begin
            words++;
            n_checks++; if (bus5.out_addr !== 5'd5) begin n_fail++; $display("FAIL single_addr: got %0d expected 5", bus5.out_addr); end
            n_checks++; if (bus5.out_data !== 32'h1005) begin n_fail++; $display("FAIL single_data: got %h expected 00001005", bus5.out_data); end
         end
         if (bus5.done) begin dones++; done_k = k; end
         if (k == 2) bus5.start = 1'b0;
         tick();
      end
      n_checks++; if (words != 1) begin n_fail++; $display("FAIL single_word_count: got %0d expected 1", words); end
      n_checks++; if (dones != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", dones); end
      n_checks++; if (done_k != 2) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 2", done_k); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.start = 1'b0;  bus.abort = 1'b0;  bus.out_ready = 1'b0;
      bus5.start = 1'b0; bus5.abort = 1'b0; bus5.out_ready = 1'b0;
      test_reset();
      test_full_dump();
      test_stall();
      test_abort();
      test_reset_mid();
      test_single_reg();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter FIRST_REG, default 0: first register index dumped.
REQ-002 Parameter LAST_REG, default 31: last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request one dump pass; sampled only in IDLE.
REQ-006 abort  input  1  terminate an in-progress pass; no done pulse.
REQ-007 rd_addr  output  5  register-file read address; drives the C read port.
REQ-008 rd_data  input  32  combinational register-file read data for rd_addr; index 0 reads 0.
REQ-009 out_valid  output  1  out_addr/out_data hold a valid word.
REQ-010 out_ready  input  1  consumer accepts the word.
REQ-011 out_addr  output  5  register index of out_data.
REQ-012 out_data  output  32  captured register value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the LAST_REG word is accepted.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, SEND, DONE.
REQ-016 IDLE: when start=1, it SHALL load idx=FIRST_REG and go to ISSUE; otherwise it SHALL stay.
REQ-017 ISSUE: rd_addr SHALL equal idx, and the next edge SHALL capture out_data<=rd_data and out_addr<=idx, then go to SEND.
REQ-018 SEND: out_valid SHALL be 1, and out_addr/out_data SHALL stay stable until the handshake completes.
REQ-019 Handshake = out_valid & out_ready at a clock edge. On handshake, idx==LAST_REG goes to DONE, else idx<=idx+1 and go to ISSUE.
REQ-020 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-021 Latency: start sampled at edge N gives out_valid high from edge N+2. Throughput is one word per 2 cycles with out_ready held high.
REQ-022 out_ready low in SEND SHALL stall indefinitely with no data change. out_valid SHALL never drop before the handshake.
REQ-023 start while busy SHALL be ignored (no queueing, no restart).
REQ-024 abort=1 in ISSUE or SEND SHALL go to IDLE next cycle and drop out_valid, with no done pulse; abort has priority over a same-cycle handshake.
REQ-025 abort in IDLE or DONE SHALL have no effect; a DONE pulse is never suppressed.
REQ-026 idx SHALL be 5 bits and SHALL never wrap, because termination compares against LAST_REG before incrementing.
REQ-027 FIRST_REG==LAST_REG SHALL produce exactly one word followed by done.
REQ-028 rd_addr SHALL be 0 outside ISSUE, so idle reads are benign.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, idx=0, out_valid=0, out_addr=0, out_data=0, done=0, busy=0, rd_addr=0.
REQ-030 Reset mid-pass SHALL discard the pass silently, with no done pulse and no partial word presented afterwards.

Structure
REQ-031 The state encoding constants and the 5-bit register-index width SHALL reside in the shared CPU constants package, for reuse by the register file and control unit.
REQ-032 The block SHALL be a single module with no sub-modules; the FSM and datapath are inline.
REQ-033 Outputs out_valid, out_addr, out_data and done SHALL be registered. rd_addr and busy may be decoded from state.

Verification
REQ-034 Register file preloaded with r[i]=0x1000+i, out_ready=1, start pulse -> 32 words, addr 0..31, data 0 then 0x1001..0x101F, done once, 64 cycles from start to done.
REQ-035 out_ready low for 5 cycles at idx=7 -> out_addr=7 and out_data=0x1007 stable for all 5 cycles, then idx 8 follows.
REQ-036 abort in SEND at idx=10 with out_ready=1 in the same cycle -> word 10 not counted, busy=0 next cycle, no done.
REQ-037 rst_n=0 for one edge at idx=20 -> all outputs 0 next cycle; a subsequent start restarts from FIRST_REG.
REQ-038 FIRST_REG=LAST_REG=5, start asserted again while busy -> exactly one word (addr 5), one done, the second start ignored.
